// File: rtl/preamble_sfd_rx_if.sv
// Receive-side bundle for preamble_sfd_rx: GMII-style byte input plus payload/status outputs.
// slave = the stripper itself, master = whoever feeds bytes and watches the results.
interface preamble_sfd_rx_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       preamble_sfd_rx_done;
    logic       preamble_err;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_last;
    logic       rx_frame_done;

    modport slave (
        input  data_in, data_in_valid,
        output preamble_sfd_rx_done, preamble_err, data_out, data_out_valid,
               data_out_last, rx_frame_done
    );

    modport master (
        output data_in, data_in_valid,
        input  preamble_sfd_rx_done, preamble_err, data_out, data_out_valid,
               data_out_last, rx_frame_done
    );
endinterface

// File: rtl/preamble_sfd_rx.sv
// Strips 0x55 preamble + 0xD5 SFD from a GMII-style byte stream and emits the payload with a last flag.
// Latency: payload byte sampled on edge k leaves after edge k+1; no backpressure, input is free-running.
module preamble_sfd_rx #(
    parameter int PREAMBLE_MIN = 1,
    parameter int PREAMBLE_MAX = 7
) (
    input  logic              aclk,
    input  logic              aresetn,
    preamble_sfd_rx_if.slave  rx
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

    localparam logic [2:0] MIN_C    = 3'(PREAMBLE_MIN);
    localparam logic [2:0] MAX_C    = 3'(PREAMBLE_MAX);
    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    state_t     r_state,    w_state_nxt;
    logic [2:0] r_cnt,      w_cnt_nxt;
    logic [7:0] r_hold,     w_hold_nxt;
    logic       r_hold_vld, w_hold_vld_nxt;
    logic [7:0] r_dout,     w_dout_nxt;
    logic       r_dout_vld, w_dout_vld_nxt;
    logic       r_last,     w_last_nxt;
    logic       r_done,     w_done_nxt;
    logic       r_err,      w_err_nxt;
    logic       r_fdone,    w_fdone_nxt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // DROP on reset so a frame already in flight is discarded until rx_dv drops
            r_state    <= DROP;
            r_cnt      <= 3'd0;
            r_hold     <= 8'h00;
            r_hold_vld <= 1'b0;
            r_dout     <= 8'h00;
            r_dout_vld <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_fdone    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hold     <= w_hold_nxt;
            r_hold_vld <= w_hold_vld_nxt;
            r_dout     <= w_dout_nxt;
            r_dout_vld <= w_dout_vld_nxt;
            r_last     <= w_last_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_fdone    <= w_fdone_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hold_nxt     = r_hold;
        w_hold_vld_nxt = r_hold_vld;
        w_dout_nxt     = r_dout;
        w_dout_vld_nxt = 1'b0;
        w_last_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_fdone_nxt    = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (rx.data_in_valid) begin
                    if (rx.data_in == PRE_BYTE) begin
                        w_state_nxt = PREAMBLE;
                        w_cnt_nxt   = 3'd1;
                    end else begin
                        w_state_nxt = DROP;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                w_err_nxt = 1'b1;
                w_cnt_nxt = 3'd0;
                if (!rx.data_in_valid) begin
                    w_state_nxt = IDLE;
                end else if (rx.data_in == PRE_BYTE && r_cnt < MAX_C) begin
                    w_err_nxt = 1'b0;
                    w_cnt_nxt = r_cnt + 3'd1;
                end else if (rx.data_in == SFD_BYTE && r_cnt >= MIN_C) begin
                    w_err_nxt      = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_hold_vld_nxt = 1'b0;
                    w_state_nxt    = PAYLOAD;
                end else begin
                    w_state_nxt = DROP;
                end
            end
            PAYLOAD: begin
                // One-byte skid lets the final byte be tagged last when rx_dv falls
                if (rx.data_in_valid) begin
                    w_hold_nxt     = rx.data_in;
                    w_hold_vld_nxt = 1'b1;
                    if (r_hold_vld) begin
                        w_dout_nxt     = r_hold;
                        w_dout_vld_nxt = 1'b1;
                    end
                end else begin
                    if (r_hold_vld) begin
                        w_dout_nxt     = r_hold;
                        w_dout_vld_nxt = 1'b1;
                        w_last_nxt     = 1'b1;
                    end
                    w_fdone_nxt    = 1'b1;
                    w_hold_vld_nxt = 1'b0;
                    w_state_nxt    = IDLE;
                end
            end
            DROP: begin
                if (!rx.data_in_valid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = DROP;
        endcase
    end

    assign rx.preamble_sfd_rx_done = r_done;
    assign rx.preamble_err         = r_err;
    assign rx.data_out             = r_dout;
    assign rx.data_out_valid       = r_dout_vld;
    assign rx.data_out_last        = r_last;
    assign rx.rx_frame_done        = r_fdone;
endmodule

// File: tb/tb_preamble_sfd_rx.sv
// Bench for preamble_sfd_rx: directed frames plus random frames against a frame-level reference model.
module tb_preamble_sfd_rx;
    localparam int P_MIN = 1;
    localparam int P_MAX = 7;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    preamble_sfd_rx_if rx_if();

    preamble_sfd_rx #(
        .PREAMBLE_MIN (P_MIN),
        .PREAMBLE_MAX (P_MAX)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .rx      (rx_if.slave)
    );

    always #5 aclk = ~aclk;

    int n_vec     = 0;
    int n_miscmp  = 0;

    logic [7:0] fb[$];
    logic       e_done[64];
    logic       e_err[64];
    logic       e_dov[64];
    logic       e_last[64];
    logic       e_fdone[64];
    logic [7:0] e_dout[64];
    logic [7:0] m_dout;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miscmp++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic done, input logic err, input logic dov,
                              input logic last, input logic fdone);
        check_val({tag, ".done"},  32'(rx_if.preamble_sfd_rx_done), 32'(done));
        check_val({tag, ".err"},   32'(rx_if.preamble_err),         32'(err));
        check_val({tag, ".dov"},   32'(rx_if.data_out_valid),       32'(dov));
        check_val({tag, ".last"},  32'(rx_if.data_out_last),        32'(last));
        check_val({tag, ".fdone"}, 32'(rx_if.rx_frame_done),        32'(fdone));
        check_val({tag, ".dout"},  32'(rx_if.data_out),             32'(m_dout));
    endtask

    // Frame-level rules: count leading 0x55s, classify the byte that ends the run,
    // and place each event at the edge index where its effect becomes visible.
    task automatic build_expect();
        int n;
        int p;
        n = fb.size();
        for (int i = 0; i < 64; i++) begin
            e_done[i] = 0; e_err[i] = 0; e_dov[i] = 0;
            e_last[i] = 0; e_fdone[i] = 0; e_dout[i] = 8'h00;
        end
        p = 0;
        while (p < n && fb[p] == 8'h55) p++;
        if (p == 0) begin
            if (n > 0) e_err[0] = 1;
        end else if (p > P_MAX) begin
            e_err[P_MAX] = 1;
        end else if (p == n) begin
            e_err[n] = 1;
        end else if (fb[p] == 8'hD5 && p >= P_MIN) begin
            e_done[p] = 1;
            for (int i = p + 1; i < n; i++) begin
                e_dov[i + 1]  = 1;
                e_dout[i + 1] = fb[i];
            end
            e_last[n]  = (n > p + 1);
            e_fdone[n] = 1;
        end else begin
            e_err[p] = 1;
        end
    endtask

    task automatic drive_cycle(input logic vld, input logic [7:0] b);
        rx_if.data_in_valid = vld;
        rx_if.data_in       = b;
        @(posedge aclk);
        #1;
    endtask

    task automatic run_frame(input string tag, input int gap, input int stop_at);
        int n;
        int total;
        n     = fb.size();
        total = n + gap;
        if (stop_at >= 0) total = stop_at;
        build_expect();
        for (int e = 0; e < total; e++) begin
            drive_cycle(e < n, (e < n) ? fb[e] : 8'($urandom));
            if (e_dov[e]) m_dout = e_dout[e];
            check_outs($sformatf("%s.e%0d", tag, e), e_done[e], e_err[e], e_dov[e], e_last[e], e_fdone[e]);
        end
    endtask

    task automatic push_good(input int plen, input int nbytes, input logic [7:0] first);
        fb.delete();
        for (int i = 0; i < plen; i++) fb.push_back(8'h55);
        fb.push_back(8'hD5);
        for (int i = 0; i < nbytes; i++) fb.push_back(first + 8'(i));
    endtask

    initial begin
        rx_if.data_in_valid = 1'b0;
        rx_if.data_in       = 8'h00;
        m_dout              = 8'h00;
        #12;
        check_outs("reset", 0, 0, 0, 0, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        drive_cycle(0, 8'h00);
        check_outs("post_reset", 0, 0, 0, 0, 0);

        push_good(7, 4, 8'h01);
        run_frame("c1", 2, -1);

        push_good(1, 0, 8'h00);
        fb.push_back(8'hAA);
        run_frame("c2", 1, -1);

        fb.delete();
        repeat (3) fb.push_back(8'h55);
        fb.push_back(8'h12);
        repeat (4) fb.push_back(8'($urandom));
        run_frame("c3", 1, -1);
        push_good(7, 4, 8'h30);
        run_frame("c3_next", 1, -1);

        fb.delete();
        repeat (8) fb.push_back(8'h55);
        fb.push_back(8'hD5);
        run_frame("c4", 1, -1);

        push_good(7, 0, 8'h00);
        run_frame("c5", 2, -1);

        fb.delete();
        repeat (3) fb.push_back(8'h55);
        fb.push_back(8'h55);
        run_frame("trunc", 1, -1);

        // Reset lands mid-payload; rx_dv stays high through and after the release.
        fb = '{8'h55, 8'h55, 8'hD5, 8'hAA, 8'hBB};
        run_frame("c6_pre", 1, 5);
        #2;
        aresetn = 1'b0;
        #1;
        m_dout = 8'h00;
        check_outs("c6_rst", 0, 0, 0, 0, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1, 8'($urandom));
            check_outs($sformatf("c6_drop%0d", i), 0, 0, 0, 0, 0);
        end
        drive_cycle(0, 8'h00);
        check_outs("c6_gap", 0, 0, 0, 0, 0);
        push_good(3, 3, 8'hC0);
        run_frame("c6_next", 1, -1);

        for (int f = 0; f < 300; f++) begin
            int plen;
            int kind;
            int plen_pay;
            plen     = $urandom_range(0, 9);
            kind     = $urandom_range(0, 3);
            plen_pay = $urandom_range(0, 6);
            fb.delete();
            for (int i = 0; i < plen; i++) fb.push_back(8'h55);
            if (kind <= 1) fb.push_back(8'hD5);
            else if (kind == 2) fb.push_back(8'($urandom));
            if (kind != 3) begin
                for (int i = 0; i < plen_pay; i++) fb.push_back(8'($urandom));
            end
            run_frame($sformatf("rnd%0d", f), $urandom_range(1, 3), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
